// File: rtl/sink_capture_ctrl_if.sv
// Bus bundle between the capture sink, the upstream FIFO channels and the
// capture RAM. master = the capture controller, slave = FIFOs/RAM side.
interface sink_capture_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH-1:0]            rd_en_o;
  logic [NUM_CH-1:0]            empty_i;
  logic [NUM_CH*DATA_WIDTH-1:0] data_i;
  logic                         mem_we_o;
  logic [ADDR_WIDTH-1:0]        mem_addr_o;
  logic [DATA_WIDTH-1:0]        mem_data_o;

  modport master (
    output rd_en_o,
    input  empty_i,
    input  data_i,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o
  );

  modport slave (
    input  rd_en_o,
    output empty_i,
    output data_i,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o
  );
endinterface

// File: rtl/sink_capture_ctrl.sv
// Multi-channel capture sink: drains one selected FIFO channel into sample
// memory from a base address, one-shot or as a ring buffer, with abort.
//
// state   | meaning
// S_IDLE  | waiting for start_i; configuration latched on start
// S_RUN   | issuing FIFO reads, writing returned samples
// S_DRAIN | no new reads; waiting for in-flight reads to be written
// S_DONE  | capture finished; done_o pulses on the following cycle
module sink_capture_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 7,
  parameter  int NUM_CH     = 2,
  parameter  int RD_LAT     = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  circ_i,
  input  logic [CH_W-1:0]       ch_sel_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  sink_capture_ctrl_if.master   bus,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  busy_o,
  output logic                  wrapped_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic                  r_circ;
  logic [CH_W-1:0]       r_sel;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_issued;
  logic [RD_LAT-1:0]     r_vld;

  logic                  w_empty_sel;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_fire;

  // Select the latched channel's empty flag and read data.
  always_comb begin
    w_empty_sel = 1'b1;
    w_data      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_sel == c[CH_W-1:0]) begin
        w_empty_sel = bus.empty_i[c];
        w_data      = bus.data_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // abort_i blocks a read in the very cycle it is raised.
  assign w_fire = (r_state == S_RUN) && !abort_i && !w_empty_sel && (r_issued < r_len);

  // Read enable is the only combinational output, one-hot on the selected channel.
  always_comb begin
    bus.rd_en_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_fire && (r_sel == c[CH_W-1:0])) bus.rd_en_o[c] = 1'b1;
    end
  end

  // Control FSM, read-latency pipe and memory write stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_circ         <= 1'b0;
      r_sel          <= '0;
      r_base         <= '0;
      r_len          <= '0;
      r_issued       <= '0;
      r_vld          <= '0;
      bus.mem_we_o   <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
      count_o        <= '0;
      busy_o         <= 1'b0;
      wrapped_o      <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) r_vld[k] <= r_vld[k-1];
      r_vld[0]     <= w_fire;
      bus.mem_we_o <= r_vld[RD_LAT-1];
      done_o       <= (r_state == S_DONE);

      // Sample is valid on data_i now; it is written on the next cycle.
      if (r_vld[RD_LAT-1]) begin
        bus.mem_data_o <= w_data;
        bus.mem_addr_o <= r_base + count_o;
        if (r_circ && (count_o + ADDR_ONE == r_len)) begin
          count_o   <= '0;
          wrapped_o <= 1'b1;
        end else begin
          count_o <= count_o + ADDR_ONE;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_circ    <= circ_i;
            r_sel     <= ch_sel_i;
            r_base    <= base_i;
            r_len     <= len_i;
            r_issued  <= '0;
            count_o   <= '0;
            wrapped_o <= 1'b0;
            if (len_i == '0) begin
              r_state <= S_DONE;
              busy_o  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              busy_o  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (r_circ && (r_issued + ADDR_ONE == r_len)) r_issued <= '0;
            else                                          r_issued <= r_issued + ADDR_ONE;
          end
          if (abort_i || (!r_circ && (r_issued == r_len))) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_vld == '0) begin
            r_state <= S_DONE;
            busy_o  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sink_capture_ctrl.sv
// Directed bench for sink_capture_ctrl: one instance with RD_LAT=1 and one
// with RD_LAT=3, each fed by a small FIFO model and logged by a write monitor.
module tb_sink_capture_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start1, abort1, start3, abort3, circ;
  logic [0:0] ch_sel;
  logic [6:0] base, len;
  logic [1:0] empty1, empty3;
  logic [6:0] count1, count3;
  logic       busy1, wrapped1, done1, busy3, wrapped3, done3;

  int vectors = 0;
  int miscompares = 0;

  sink_capture_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_CH(2)) bus1 ();
  sink_capture_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_CH(2)) bus3 ();

  sink_capture_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_CH(2), .RD_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .start_i(start1), .abort_i(abort1), .circ_i(circ),
    .ch_sel_i(ch_sel), .base_i(base), .len_i(len), .bus(bus1.master),
    .count_o(count1), .busy_o(busy1), .wrapped_o(wrapped1), .done_o(done1)
  );

  sink_capture_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_CH(2), .RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .start_i(start3), .abort_i(abort3), .circ_i(circ),
    .ch_sel_i(ch_sel), .base_i(base), .len_i(len), .bus(bus3.master),
    .count_o(count3), .busy_o(busy3), .wrapped_o(wrapped3), .done_o(done3)
  );

  always #5 clk = ~clk;

  // FIFO models: word = {prefix, channel, 8-bit pop index}
  logic [7:0]  ptr1 [2] = '{8'd0, 8'd0};
  logic [7:0]  ptr3 [2] = '{8'd0, 8'd0};
  logic [15:0] dout1 [2] = '{16'd0, 16'd0};
  logic [15:0] p3a [2] = '{16'd0, 16'd0};
  logic [15:0] p3b [2] = '{16'd0, 16'd0};
  logic [15:0] dout3 [2] = '{16'd0, 16'd0};
  int rd1 [2] = '{0, 0};
  int rd3 [2] = '{0, 0};
  int rdemp1 = 0;
  int dn1 = 0;
  int dn3 = 0;
  logic [6:0]  wa1 [$];
  logic [15:0] wd1 [$];
  logic [6:0]  wa3 [$];
  logic [15:0] wd3 [$];

  assign bus1.empty_i = empty1;
  assign bus3.empty_i = empty3;
  assign bus1.data_i  = {dout1[1], dout1[0]};
  assign bus3.data_i  = {dout3[1], dout3[0]};

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (bus1.rd_en_o[c]) begin
        dout1[c] <= {4'hA, c[3:0], ptr1[c]};
        ptr1[c]  <= ptr1[c] + 8'd1;
        rd1[c]   <= rd1[c] + 1;
        if (empty1[c]) rdemp1 <= rdemp1 + 1;
      end
      if (bus3.rd_en_o[c]) begin
        p3a[c]  <= {4'hB, c[3:0], ptr3[c]};
        ptr3[c] <= ptr3[c] + 8'd1;
        rd3[c]  <= rd3[c] + 1;
      end
      p3b[c]   <= p3a[c];
      dout3[c] <= p3b[c];
    end
    if (bus1.mem_we_o) begin
      wa1.push_back(bus1.mem_addr_o);
      wd1.push_back(bus1.mem_data_o);
    end
    if (bus3.mem_we_o) begin
      wa3.push_back(bus3.mem_addr_o);
      wd3.push_back(bus3.mem_data_o);
    end
    if (done1) dn1 <= dn1 + 1;
    if (done3) dn3 <= dn3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [3:0] pfx, input int c, input int p);
    return {16'd0, pfx, c[3:0], p[7:0]};
  endfunction

  int k, n0, s, r0, r1, d0, e0;

  initial begin
    rstn = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    circ = 1'b0; ch_sel = 1'b0; base = 7'd0; len = 7'd0; empty1 = 2'b00; empty3 = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_flags", 32'({wrapped1, done1, bus1.mem_we_o}), 0);
    check("rst_addr_data", 32'({bus1.mem_addr_o, bus1.mem_data_o}), 0);
    check("rst_rd_en", 32'(bus1.rd_en_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    // one-shot, ch1, base 10, len 5
    ch_sel = 1'b1; base = 7'd10; len = 7'd5; circ = 1'b0;
    n0 = wa1.size(); s = int'(ptr1[1]); r0 = rd1[0]; r1 = rd1[1]; d0 = dn1;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; k = 1;
    check("t1_busy", 32'(busy1), 1);
    check("t1_rd_en", 32'(bus1.rd_en_o), 2);
    while (done1 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("t1_done_cyc", k, 9);
    check("t1_nwr", wa1.size() - n0, 5);
    for (int i = 0; i < 5; i++) begin
      check("t1_addr", 32'(wa1[n0+i]), 10 + i);
      check("t1_data", 32'(wd1[n0+i]), word(4'hA, 1, s + i));
    end
    @(negedge clk);
    check("t1_done_pulses", dn1 - d0, 1);
    check("t1_busy_end", 32'(busy1), 0);
    check("t1_count", 32'(count1), 5);
    check("t1_rd_ch1", rd1[1] - r1, 5);
    check("t1_rd_ch0", rd1[0] - r0, 0);

    // empty stalls, ch0, base 20, len 4; ch1 held empty and ignored
    ch_sel = 1'b0; base = 7'd20; len = 7'd4; empty1 = 2'b10;
    n0 = wa1.size(); s = int'(ptr1[0]); r0 = rd1[0]; r1 = rd1[1]; e0 = rdemp1;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; k = 1;
    while (done1 !== 1'b1 && k < 60) begin
      empty1[0] = ~empty1[0];
      @(negedge clk); k++;
    end
    check("t2_done_seen", 32'(done1), 1);
    check("t2_nwr", wa1.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", 32'(wa1[n0+i]), 20 + i);
      check("t2_data", 32'(wd1[n0+i]), word(4'hA, 0, s + i));
    end
    check("t2_rd_while_empty", rdemp1 - e0, 0);
    check("t2_rd_ch0", rd1[0] - r0, 4);
    check("t2_rd_ch1", rd1[1] - r1, 0);
    check("t2_count", 32'(count1), 4);
    empty1 = 2'b00;
    @(negedge clk);

    // address wrap past top of memory
    ch_sel = 1'b1; base = 7'd126; len = 7'd4;
    n0 = wa1.size(); s = int'(ptr1[1]);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; k = 1;
    while (done1 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("t3_done_cyc", k, 8);
    check("t3_nwr", wa1.size() - n0, 4);
    check("t3_addr0", 32'(wa1[n0]), 126);
    check("t3_addr1", 32'(wa1[n0+1]), 127);
    check("t3_addr2", 32'(wa1[n0+2]), 0);
    check("t3_addr3", 32'(wa1[n0+3]), 1);
    check("t3_data3", 32'(wd1[n0+3]), word(4'hA, 1, s + 3));
    @(negedge clk);

    // circular, len 3, base 0, abort after 8 reads
    circ = 1'b1; ch_sel = 1'b1; base = 7'd0; len = 7'd3;
    n0 = wa1.size(); s = int'(ptr1[1]); r1 = rd1[1]; d0 = dn1;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) check("t4_wrap_early", 32'(wrapped1), 0);
      if (c == 6) check("t4_wrap_set", 32'(wrapped1), 1);
      @(negedge clk);
    end
    abort1 = 1'b1;
    #1 check("t4_abort_blocks", 32'(bus1.rd_en_o), 0);
    @(negedge clk); abort1 = 1'b0; k = 10;
    while (done1 !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    check("t4_done_seen", 32'(done1), 1);
    check("t4_rd", rd1[1] - r1, 8);
    check("t4_nwr", wa1.size() - n0, 8);
    for (int i = 0; i < 8; i++) begin
      check("t4_addr", 32'(wa1[n0+i]), i % 3);
      check("t4_data", 32'(wd1[n0+i]), word(4'hA, 1, s + i));
    end
    @(negedge clk);
    check("t4_count", 32'(count1), 2);
    check("t4_wrapped_hold", 32'(wrapped1), 1);
    check("t4_done_pulses", dn1 - d0, 1);
    circ = 1'b0;

    // zero length
    len = 7'd0; base = 7'd3;
    n0 = wa1.size(); r0 = rd1[0]; r1 = rd1[1];
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; k = 1;
    check("t5_busy", 32'(busy1), 0);
    check("t5_wrapped_clr", 32'(wrapped1), 0);
    while (done1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("t5_done_cyc", k, 2);
    check("t5_nwr", wa1.size() - n0, 0);
    check("t5_rd", (rd1[0] - r0) + (rd1[1] - r1), 0);
    check("t5_count", 32'(count1), 0);
    @(negedge clk);

    // RD_LAT=3, abort one cycle after the first read
    ch_sel = 1'b1; base = 7'd5; len = 7'd4;
    n0 = wa3.size(); s = int'(ptr3[1]); r1 = rd3[1]; d0 = dn3;
    start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    check("t6_rd_first", 32'(bus3.rd_en_o), 2);
    @(negedge clk); abort3 = 1'b1;
    #1 check("t6_rd_blocked", 32'(bus3.rd_en_o), 0);
    @(negedge clk); abort3 = 1'b0; k = 3;
    while (done3 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("t6_done_cyc", k, 7);
    check("t6_rd", rd3[1] - r1, 1);
    check("t6_nwr", wa3.size() - n0, 1);
    check("t6_addr", 32'(wa3[n0]), 5);
    check("t6_data", 32'(wd3[n0]), word(4'hB, 1, s));
    @(negedge clk);
    check("t6_count", 32'(count3), 1);
    check("t6_done_pulses", dn3 - d0, 1);

    // reset in the middle of a run after two writes
    ch_sel = 1'b0; base = 7'd40; len = 7'd6;
    n0 = wa1.size(); d0 = dn1;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (4) @(negedge clk);
    check("t7_nwr_before", wa1.size() - n0, 2);
    rstn = 1'b0;
    #1;
    check("t7_rst_count", 32'(count1), 0);
    check("t7_rst_busy", 32'(busy1), 0);
    check("t7_rst_we", 32'(bus1.mem_we_o), 0);
    check("t7_rst_rd_en", 32'(bus1.rd_en_o), 0);
    check("t7_rst_addr_data", 32'({bus1.mem_addr_o, bus1.mem_data_o}), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_nwr_after", wa1.size() - n0, 2);
    check("t7_no_done", dn1 - d0, 0);
    len = 7'd2;
    n0 = wa1.size(); s = int'(ptr1[0]);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; k = 1;
    while (done1 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("t7_done_cyc", k, 6);
    check("t7_nwr_new", wa1.size() - n0, 2);
    check("t7_addr0", 32'(wa1[n0]), 40);
    check("t7_addr1", 32'(wa1[n0+1]), 41);
    check("t7_data0", 32'(wd1[n0]), word(4'hA, 0, s));
    check("t7_data1", 32'(wd1[n0+1]), word(4'hA, 0, s + 1));
    check("t7_count", 32'(count1), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sink_capture_ctrl.md
Name: sink_capture_ctrl

Overview:
Parametrised multi-channel capture sink. It drains one selected upstream FIFO channel into a sample memory, from a programmable base address for a programmable length. Supports one-shot and circular (ring-buffer) capture, abort, and a configurable FIFO read latency. It sits between the interpolator output FIFOs and the capture RAM, and is used in simulation and on-chip capture.

Parameters:
DATA_WIDTH, 16, sample width per channel
ADDR_WIDTH, 7, memory address width; also the width of the length and count fields
NUM_CH, 2, number of upstream FIFO channels (1..8)
RD_LAT, 1, cycles from rd_en_o to valid FIFO data (1..3)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  start capture; sampled only in IDLE
abort_i  in  1  stop issuing reads; drain and finish
circ_i  in  1  0 = one-shot, 1 = circular; latched at start
ch_sel_i  in  $clog2(NUM_CH) (min 1)  channel to capture; latched at start
base_i  in  ADDR_WIDTH  first write address; latched at start
len_i  in  ADDR_WIDTH  samples per pass; latched at start
empty_i  in  NUM_CH  per-channel FIFO empty
data_i  in  NUM_CH*DATA_WIDTH  per-channel FIFO read data, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
rd_en_o  out  NUM_CH  per-channel FIFO read enable, one-hot or zero
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  memory write address
mem_data_o  out  DATA_WIDTH  memory write data
count_o  out  ADDR_WIDTH  writes completed in current pass
busy_o  out  1  high in RUN and DRAIN
wrapped_o  out  1  sticky: at least one circular wrap since start
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rstn low): state IDLE; all outputs 0; internal issue counter, write counter and latency pipe cleared. Asserting reset mid-capture aborts without a done_o pulse.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered except rd_en_o, which is combinational from state, counters, abort_i and empty_i.
- IDLE: on start_i, latch circ_i, ch_sel_i, base_i and len_i, and clear wrapped_o. If len_i == 0, go to DONE; otherwise go to RUN. start_i is ignored outside IDLE.
- RUN, read issue: rd_en_o[sel] = 1 when empty_i[sel] == 0, issued < len and abort_i == 0. Each issue increments the issued counter. Empty flags of non-selected channels are ignored.
- Write: a RD_LAT-deep valid shift register tracks each read. RD_LAT cycles after a read, data_i[sel] is registered and emitted one cycle later:
  - mem_we_o = 1, mem_data_o = that sample, mem_addr_o = base + count (mod 2^ADDR_WIDTH; wraps silently past the top of memory);
  - count_o increments in the same cycle.
  - Total rd_en_o-to-mem_we_o latency: RD_LAT + 1 cycles. Back-to-back reads give one write per cycle.
- One-shot: when issued == len, go to DRAIN.
- Circular: when issued reaches len, the issued counter resets to 0 in the same cycle; reads continue with no bubble.
  - When the write for sample len-1 completes, count_o returns to 0 the next cycle (the address returns to base) and wrapped_o sets.
  - Capture runs until abort_i.
- abort_i in RUN: blocks reads in the same cycle; go to DRAIN. In-flight reads are still written.
- DRAIN: no reads issued. When the pipe is empty and no write is pending, go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. busy_o is 0 in DONE. count_o and wrapped_o hold until the next start.
- Simultaneous events:
  - abort_i in the same cycle as the last one-shot read: that read issues only if abort_i is low.
  - abort_i in IDLE or DONE has no effect.
  - start_i and abort_i together in IDLE: the start is taken; the abort is ignored.
- len_i = 2^ADDR_WIDTH − 1 is the maximum supported length.

Test Plan:
- One-shot, NUM_CH=2, RD_LAT=1, ch_sel=1, base=10, len=5, FIFO always non-empty -> 5 consecutive rd_en_o[1] pulses; mem_we_o at addresses 10..14, data in FIFO order; count_o=5; done_o pulses once, 2 cycles after the last write completes; rd_en_o[0] never asserted.
- Empty stalls: len=4, empty_i[sel] toggles every other cycle -> reads only when not empty; exactly 4 writes at base..base+3; no write is issued while the FIFO is empty.
- Address wrap: ADDR_WIDTH=7, base=126, len=4 -> write addresses 126, 127, 0, 1.
- Circular: len=3, base=0, FIFO non-empty, abort after 8 reads -> addresses 0,1,2,0,1,2,0,1; wrapped_o set after the 3rd write; in-flight reads drained; done_o pulses; count_o=2.
- Zero length and abort timing: len=0 -> done_o pulses 2 cycles after start_i with no reads. RD_LAT=3, abort_i asserted 1 cycle after the first read -> 1 read and 1 write, then done_o.
- Reset mid-RUN after 2 writes -> all outputs 0 immediately; no done_o; a new start with len=2 captures correctly from base.
